// File: rtl/coloring_search_ctrl.sv
// rtl/coloring_search_ctrl.sv - brute-force colouring enumerator driving a combinational checker
module coloring_search_ctrl #(
    parameter int N_VERT     = 11,
    parameter int COLOR_BITS = 2,
    parameter int N_COLORS   = 4,
    parameter int CHK_LAT    = 0,
    parameter int CNT_W      = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic                         ok_i,
    output logic [N_VERT*COLOR_BITS-1:0] cand_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         found_o,
    output logic [N_VERT*COLOR_BITS-1:0] sol_o,
    output logic [CNT_W-1:0]             tried_o
);

    localparam int CW = N_VERT * COLOR_BITS;
    localparam int WW = (CHK_LAT > 0) ? $clog2(CHK_LAT + 1) : 1;
    localparam logic [COLOR_BITS-1:0] DMAX = COLOR_BITS'(N_COLORS - 1);
    localparam logic [WW-1:0] LAT = WW'(CHK_LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cand_q;
    logic [CW-1:0]   sol_q;
    logic [CNT_W-1:0] tried_q;
    logic [WW-1:0]   wait_q;
    logic            busy_q;
    logic            done_q;
    logic            found_q;

    logic [CW-1:0]   cand_d;
    logic            cand_last;

    // Mixed-radix increment, vertex 0 least significant; digits never exceed N_COLORS-1.
    always_comb begin
        logic                  carry;
        logic [COLOR_BITS-1:0] digit;
        cand_d    = cand_q;
        cand_last = 1'b1;
        carry     = 1'b1;
        for (int i = 0; i < N_VERT; i++) begin
            digit = cand_q[COLOR_BITS*i +: COLOR_BITS];
            if (digit != DMAX) cand_last = 1'b0;
            if (carry) begin
                if (digit == DMAX) begin
                    cand_d[COLOR_BITS*i +: COLOR_BITS] = '0;
                end else begin
                    cand_d[COLOR_BITS*i +: COLOR_BITS] = digit + 1'b1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            sol_q   <= '0;
            tried_q <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            found_q <= 1'b0;
        end else if (abort_i) begin
            // Results stay frozen so software can inspect how far the search got.
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q <= S_RUN;
                        cand_q  <= '0;
                        sol_q   <= '0;
                        tried_q <= '0;
                        found_q <= 1'b0;
                        wait_q  <= LAT;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - 1'b1;
                    end else begin
                        tried_q <= tried_q + 1'b1;
                        if (ok_i) begin
                            sol_q   <= cand_q;
                            found_q <= 1'b1;
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (cand_last) begin
                            found_q <= 1'b0;
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cand_q <= cand_d;
                            wait_q <= LAT;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cand_o  = cand_q;
    assign sol_o   = sol_q;
    assign tried_o = tried_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign found_o = found_q;

endmodule
